// File: rtl/tdm_demux.sv
// TDM demultiplexer: routes a serialized beat stream into per-lane holding
// registers, tracking frame alignment with a HUNT/LOCKED state machine.
module tdm_demux #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [WIDTH-1:0]         in_data,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [LANES-1:0]         out_valid,
    output logic                     frame_done,
    output logic                     sync_err,
    output logic                     locked
);

    localparam int CW = $clog2(LANES);
    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]        data_q [LANES];
    logic [LANES-1:0]        valid_q, valid_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    wr_en;
    logic [CW-1:0]           wr_lane;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < LANES; k++) data_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (wr_en) data_q[wr_lane] <= in_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_lane = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        valid_d = '0;
        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Non-SOF beats are dropped silently until alignment is found.
                    if (in_sof) begin
                        wr_en   = 1'b1;
                        cnt_d   = ONE;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_sof) begin
                        // Early SOF truncates the current frame and resyncs on this beat.
                        err_d = (cnt_q != '0);
                        wr_en = 1'b1;
                        cnt_d = ONE;
                    end else if (cnt_q == '0) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = HUNT;
                    end else begin
                        wr_en   = 1'b1;
                        wr_lane = cnt_q;
                        if (cnt_q == LAST_LANE) begin
                            done_d = 1'b1;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (wr_en) valid_d[wr_lane] = 1'b1;
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) out_data[k*WIDTH +: WIDTH] = data_q[k];
    end

    assign out_valid  = valid_q;
    assign frame_done = done_q;
    assign sync_err   = err_q;
    assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed test-plan sequences plus randomized traffic,
// all checked against a frame-level reference model.
module tb_tdm_demux;

    localparam int WIDTH = 8;
    localparam int LANES = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_sof;
    logic [WIDTH-1:0]       in_data;
    logic [LANES*WIDTH-1:0] out_data;
    logic [LANES-1:0]       out_valid;
    logic                   frame_done;
    logic                   sync_err;
    logic                   locked;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit                m_locked;
    int                m_pos;
    logic [WIDTH-1:0]  m_lane [LANES];
    logic [LANES-1:0]  e_valid;
    bit                e_done;
    bit                e_err;

    tdm_demux #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES*WIDTH-1:0] model_data();
        logic [LANES*WIDTH-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = m_lane[k];
        return r;
    endfunction

    task automatic model_update(input bit r, input bit v, input bit s, input logic [WIDTH-1:0] d);
        e_valid = '0;
        e_done  = 0;
        e_err   = 0;
        if (!r) begin
            m_locked = 0;
            m_pos    = 0;
            for (int k = 0; k < LANES; k++) m_lane[k] = '0;
        end else if (v) begin
            if (s) begin
                if (m_locked && m_pos != 0) e_err = 1;
                m_lane[0] = d;
                e_valid   = 1;
                m_pos     = 1;
                m_locked  = 1;
            end else if (m_locked) begin
                if (m_pos == 0) begin
                    e_err    = 1;
                    m_locked = 0;
                end else begin
                    m_lane[m_pos] = d;
                    e_valid       = LANES'(1) << m_pos;
                    e_done        = (m_pos == LANES - 1);
                    m_pos         = (m_pos + 1) % LANES;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input bit s, input logic [WIDTH-1:0] d);
        rst_n    = r;
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        model_update(r, v, s, d);
        #1;
        chk("out_data", 64'(out_data), 64'(model_data()));
        chk("out_valid", 64'(out_valid), 64'(e_valid));
        chk("frame_done", 64'(frame_done), 64'(e_done));
        chk("sync_err", 64'(sync_err), 64'(e_err));
        chk("locked", 64'(locked), 64'(m_locked));
        chk("onehot_valid", 64'($onehot0(out_valid)), 64'd1);
        chk("done_err_excl", 64'(frame_done & sync_err), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;

        // Reset state
        step(0, 0, 0, 8'h00);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);

        // Basic frame
        step(1, 1, 1, 8'hA0);
        chk("f1_valid0", 64'(out_valid), 64'h1);
        chk("f1_locked", 64'(locked), 64'd1);
        step(1, 1, 0, 8'hB1);
        step(1, 1, 0, 8'hC2);
        step(1, 1, 0, 8'hD3);
        chk("f1_valid3", 64'(out_valid), 64'h8);
        chk("f1_done", 64'(frame_done), 64'd1);
        chk("f1_data", 64'(out_data), 64'hD3C2B1A0);

        // HUNT discards non-SOF beats
        step(0, 0, 0, 8'h00);
        step(1, 1, 0, 8'h11);
        chk("hunt_valid", 64'(out_valid), 64'd0);
        step(1, 1, 0, 8'h22);
        chk("hunt_err", 64'(sync_err), 64'd0);
        step(1, 1, 1, 8'h33);
        chk("hunt_lane0", 64'(out_data[7:0]), 64'h33);
        chk("hunt_locked", 64'(locked), 64'd1);

        // Frame with gaps
        step(0, 0, 0, 8'h00);
        step(1, 1, 1, 8'h01);
        step(1, 0, 0, 8'hEE);
        step(1, 1, 0, 8'h02);
        step(1, 0, 1, 8'hEE);
        step(1, 1, 0, 8'h03);
        step(1, 1, 0, 8'h04);
        chk("gap_done", 64'(frame_done), 64'd1);
        chk("gap_data", 64'(out_data), 64'h04030201);

        // Early SOF
        step(1, 1, 1, 8'h10);
        step(1, 1, 0, 8'h20);
        step(1, 1, 1, 8'h30);
        chk("early_err", 64'(sync_err), 64'd1);
        chk("early_valid", 64'(out_valid), 64'h1);
        chk("early_locked", 64'(locked), 64'd1);
        step(1, 1, 0, 8'h40);
        chk("early_lane1", 64'(out_valid), 64'h2);
        chk("early_nodone", 64'(frame_done), 64'd0);

        // Missing SOF
        step(1, 1, 0, 8'h50);
        step(1, 1, 0, 8'h60);
        step(1, 1, 0, 8'h55);
        chk("miss_err", 64'(sync_err), 64'd1);
        chk("miss_data", 64'(out_data), 64'h60504030);
        chk("miss_locked", 64'(locked), 64'd0);
        step(1, 1, 1, 8'h66);
        chk("relock_lane0", 64'(out_data[7:0]), 64'h66);
        chk("relock_locked", 64'(locked), 64'd1);

        // Reset mid-frame
        step(1, 1, 0, 8'h77);
        step(0, 1, 0, 8'h88);
        chk("midrst_data", 64'(out_data), 64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        step(1, 1, 0, 8'h99);
        chk("midrst_discard", 64'(out_valid), 64'd0);
        chk("midrst_hunt", 64'(locked), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, v, s;
            r = ($urandom_range(0, 199) != 0);
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) == 0);
            step(r, v, s, WIDTH'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive-side counterpart of the team's selector/mux blocks.
- Takes one serialized sample stream, in which a TDM mux interleaves LANES channels with a start-of-frame marker on lane 0.
- Routes each beat into a per-lane holding register with a per-lane valid strobe.
- Tracks frame alignment with a HUNT/LOCKED state machine and flags sync errors.

Parameters:
- WIDTH, 8, bits per sample.
- LANES, 4, number of channels per frame. Must be >= 2; lane counter width is $clog2(LANES).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  beat present on in_data this cycle.
- in_sof  input  1  start of frame; qualifies the beat as lane 0. Ignored when in_valid=0.
- in_data  input  WIDTH  serialized sample.
- out_data  output  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]; holds its last written value.
- out_valid  output  LANES  one-cycle pulse; bit k set when lane k was updated this cycle.
- frame_done  output  1  one-cycle pulse when the last lane (LANES-1) of a frame is written.
- sync_err  output  1  one-cycle pulse on an alignment violation.
- locked  output  1  high while in the LOCKED state.

Behaviour:
- Reset: when rst_n=0 at a rising edge, the following are cleared:
  - out_data = 0, out_valid = 0, frame_done = 0, sync_err = 0, locked = 0.
  - State = HUNT, lane counter = 0.
  - Reset mid-frame discards the partial frame. Lanes already written are cleared too.
- All outputs are registered. Latency is 1 cycle: a beat accepted at edge N appears on out_data/out_valid after edge N.
- Cycles with in_valid=0: no state change; out_valid, frame_done and sync_err deassert.
- HUNT state:
  - Beats with in_sof=0 are discarded silently (no sync_err).
  - A beat with in_valid=1 and in_sof=1 writes lane 0, pulses out_valid[0], sets counter = 1 and moves to LOCKED.
- LOCKED state, beat with in_sof=0 and counter != 0:
  - Write lane[counter] and pulse out_valid[counter].
  - If counter == LANES-1: pulse frame_done in the same cycle as out_valid[LANES-1], and wrap counter to 0.
  - Otherwise counter increments.
- LOCKED state, beat with in_sof=1 and counter == 0: normal frame start. Write lane 0, counter = 1.
- LOCKED state, beat with in_sof=1 and counter != 0 (early SOF, short frame):
  - Pulse sync_err.
  - Resynchronize: write lane 0, pulse out_valid[0], counter = 1, stay LOCKED.
  - No frame_done is generated for the truncated frame.
- LOCKED state, beat with in_sof=0 and counter == 0 (missing SOF, long frame):
  - Pulse sync_err and discard the beat; no lane is written.
  - Go to HUNT with counter = 0; locked deasserts.
- Only one lane is written per cycle; out_valid is one-hot or zero.
- sync_err and frame_done are never high in the same cycle.
- Gaps (in_valid=0) of any length inside a frame are legal; the counter holds across them.

Test Plan:
- Reset, then 4 beats with in_valid=1: sof=1 with data A0, then sof=0 with B1, C2, D3. Required response:
  - out_valid pulses 0001, 0010, 0100, 1000 on consecutive cycles; locked=1 from the first beat.
  - frame_done pulses with out_valid=1000; afterwards out_data = 32'hD3C2B1A0.
- In HUNT: beats 11 and 22 with sof=0, then sof=1 with 33. Required response:
  - No out_valid and no sync_err for 11 and 22.
  - lane0 = 33, locked=1.
- Locked frame 01 02 with 1-cycle gaps between beats, then 03 04. Required response:
  - The counter holds across the gaps.
  - frame_done fires on beat 04; out_data = 32'h04030201.
- Early SOF: sof=1 10, then 20, then sof=1 30. Required response:
  - sync_err pulses on 30; lane0 = 30, out_valid = 0001, still locked.
  - Next beat 40 writes lane 1; no frame_done for the 10/20 frame.
- Missing SOF: a complete frame, then a beat 55 with sof=0. Required response:
  - sync_err pulses; out_data is unchanged; locked=0.
  - A following sof=1 beat 66 relocks with lane0 = 66.
- Reset mid-frame after 2 beats. Required response:
  - All outputs are 0 the cycle after reset.
  - A following sof=0 beat is discarded (HUNT).
